// File: rtl/pipe_stage_skid_if.sv
// Valid/ready handshake bundle carrying one pipeline instruction.
// The master drives the payload; the slave answers with ready.
interface pipe_stage_skid_if #(
   parameter int unsigned CTRL_W = 8,
   parameter int unsigned DATA_W = 32
);
   logic              valid;
   logic              ready;
   logic [CTRL_W-1:0] ctrl;
   logic [DATA_W-1:0] data;

   modport master (
      output valid,
      output ctrl,
      output data,
      input  ready
   );

   modport slave (
      input  valid,
      input  ctrl,
      input  data,
      output ready
   );
endinterface

// File: rtl/pipe_stage_skid.sv
// Handshaked pipeline-stage register with optional 2-entry skid buffer.
// Used at every RV32IM stage boundary; flush squashes all held entries.
module pipe_stage_skid #(
   parameter int unsigned       DATA_W      = 32,
   parameter int unsigned       CTRL_W      = 8,
   parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '0,
   parameter bit                SKID        = 1'b1
) (
   input  logic                CLK,
   input  logic                RESET,
   input  logic                FLUSH,
   pipe_stage_skid_if.slave    in_bus,
   pipe_stage_skid_if.master   out_bus,
   output logic [1:0]          OCCUPANCY
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   state_t            state;
   logic              out_valid_q;
   logic              in_ready_q;
   logic [CTRL_W-1:0] head_ctrl;
   logic [DATA_W-1:0] head_data;
   logic [CTRL_W-1:0] skid_ctrl;
   logic [DATA_W-1:0] skid_data;

   logic in_ready;
   logic accept;
   logic drain;

   generate
      if (SKID) begin : g_skid
         assign in_ready = in_ready_q;
      end else begin : g_noskid
         // Single entry: free a slot in the same cycle the head drains.
         assign in_ready = ~out_valid_q | out_bus.ready;
      end
   endgenerate

   assign accept = in_bus.valid & in_ready;
   assign drain  = out_valid_q & out_bus.ready;

   always_ff @(posedge CLK) begin
      if (RESET || FLUSH) begin
         state       <= EMPTY;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
         head_ctrl   <= CTRL_BUBBLE;
         head_data   <= '0;
         skid_ctrl   <= CTRL_BUBBLE;
         skid_data   <= '0;
      end else begin
         unique case (state)
            EMPTY: begin
               if (accept) begin
                  state       <= ONE;
                  out_valid_q <= 1'b1;
                  head_ctrl   <= in_bus.ctrl;
                  head_data   <= in_bus.data;
               end
            end
            ONE: begin
               unique case (1'b1)
                  accept && drain: begin
                     head_ctrl <= in_bus.ctrl;
                     head_data <= in_bus.data;
                  end
                  accept && !drain: begin
                     if (SKID) begin
                        state      <= TWO;
                        in_ready_q <= 1'b0;
                        skid_ctrl  <= in_bus.ctrl;
                        skid_data  <= in_bus.data;
                     end
                  end
                  !accept && drain: begin
                     state       <= EMPTY;
                     out_valid_q <= 1'b0;
                     head_ctrl   <= CTRL_BUBBLE;
                     head_data   <= '0;
                  end
                  default: begin
                  end
               endcase
            end
            TWO: begin
               if (drain) begin
                  state      <= ONE;
                  in_ready_q <= 1'b1;
                  head_ctrl  <= skid_ctrl;
                  head_data  <= skid_data;
                  skid_ctrl  <= CTRL_BUBBLE;
                  skid_data  <= '0;
               end
            end
            default: begin
               state       <= EMPTY;
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
               head_ctrl   <= CTRL_BUBBLE;
               head_data   <= '0;
            end
         endcase
      end
   end

   // Gate again so a stale head can never leak write enables downstream.
   assign out_bus.valid = out_valid_q;
   assign out_bus.ctrl  = out_valid_q ? head_ctrl : CTRL_BUBBLE;
   assign out_bus.data  = out_valid_q ? head_data : '0;
   assign in_bus.ready  = in_ready;
   assign OCCUPANCY     = state;

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised, handshaked pipeline-stage register for the RV32IM pipeline. It generalises the fixed EX/MEM latch into one block used for any stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB).
- It carries a control bundle and a data bundle of configurable width, with valid/ready flow control, a 2-entry skid buffer, synchronous flush, and bubble insertion.
- Stall from a downstream hazard unit or multi-cycle MUL/DIV propagates upstream through the READY signals without dropping or duplicating instructions.

Parameters:
- DATA_W, 32: width of IN_DATA/OUT_DATA (packed ALU result, store data, PC, etc.).
- CTRL_W, 8: width of IN_CTRL/OUT_CTRL (packed write-enable, mem-access, funct3, rd, etc.).
- CTRL_BUBBLE, 0: control value presented whenever the stage holds no valid instruction (NOP control).
- SKID, 1: 1 = 2-entry skid buffer (IN_READY registered); 0 = single entry (IN_READY combinational).

Ports:
- CLK  input  1  clock; all state updates on posedge.
- RESET  input  1  synchronous, active-high reset.
- FLUSH  input  1  synchronous squash of all held entries (branch mispredict/jump).
- IN_VALID  input  1  upstream presents a valid instruction.
- IN_READY  output  1  stage can accept this cycle.
- IN_CTRL  input  CTRL_W  upstream control bundle.
- IN_DATA  input  DATA_W  upstream data bundle.
- OUT_VALID  output  1  stage holds a valid instruction for downstream.
- OUT_READY  input  1  downstream accepts this cycle.
- OUT_CTRL  output  CTRL_W  control of head entry; CTRL_BUBBLE when OUT_VALID=0.
- OUT_DATA  output  DATA_W  data of head entry; 0 when OUT_VALID=0.
- OCCUPANCY  output  2  number of held entries (0, 1 or 2).

Behaviour:
- Reset: RESET=1 at posedge gives the following next-cycle values.
  - OUT_VALID=0, OUT_CTRL=CTRL_BUBBLE, OUT_DATA=0, OCCUPANCY=0, IN_READY=1.
  - The skid entry is invalidated.
  - RESET has priority over FLUSH and over all handshakes.
  - Reset mid-transfer discards both entries; no partial update.
- Transfers:
  - Accept = IN_VALID & IN_READY.
  - Drain = OUT_VALID & OUT_READY.
  - Both are evaluated at the same posedge.
- Latency: an accepted instruction appears on OUT_* the cycle after the accepting edge when the stage was empty (1-cycle latency).
- Head stability: while OUT_VALID=1 and OUT_READY=0, OUT_CTRL/OUT_DATA hold stable (no overwrite of the head).
- FSM when SKID=1 (states EMPTY, ONE, TWO):
  - EMPTY: IN_READY=1. Accept -> ONE, head<=IN. Otherwise stay.
  - ONE: IN_READY=1.
    - Accept & drain -> ONE, head<=IN.
    - Accept only -> TWO, skid<=IN.
    - Drain only -> EMPTY.
    - Neither -> ONE.
  - TWO: IN_READY=0 (a function of registered state only).
    - Drain -> ONE, head<=skid (FIFO order preserved).
    - No drain -> TWO.
- SKID=0:
  - IN_READY = ~OUT_VALID | OUT_READY (combinational).
  - TWO is unreachable; OCCUPANCY never exceeds 1.
- FLUSH (when RESET=0):
  - Next state EMPTY: OUT_VALID=0, OUT_CTRL=CTRL_BUBBLE, OUT_DATA=0, OCCUPANCY=0.
  - Any instruction accepted in the flush cycle is discarded, even though the upstream saw a handshake.
  - An instruction drained in the flush cycle counts as consumed.
  - IN_READY=1 the cycle after FLUSH.
- Simultaneous accept+drain in ONE is a pass-through; throughput is 1 instruction/cycle with no bubble.
- OCCUPANCY mirrors the state: EMPTY=0, ONE=1, TWO=2.
- Invalid entries must never leak non-bubble control downstream. Register-file and memory write enables therefore stay deasserted for bubbles regardless of stale data.
- No X values are driven after reset. Outputs contain no initial or # delays; timing is purely posedge.

Test Plan:
- Reset then idle: hold RESET 2 cycles, IN_VALID=0 -> OUT_VALID=0, OUT_CTRL=0, OUT_DATA=0, IN_READY=1, OCCUPANCY=0.
- Streaming: OUT_READY=1, present DATA 0x11,0x22,0x33 on consecutive cycles -> OUT_DATA 0x11,0x22,0x33 one cycle later each; OUT_VALID continuous; IN_READY stays 1.
- Back-pressure (SKID=1): OUT_READY=0, present 0xA0,0xB0,0xC0 -> 0xA0 accepted (ONE), 0xB0 accepted (TWO), IN_READY=0 and 0xC0 held upstream; OUT_DATA stays 0xA0. Release OUT_READY -> 0xA0,0xB0,0xC0 emerge in order; no loss or duplication.
- Flush with full buffer: state TWO (0xA0,0xB0), IN_VALID=1 with 0xC0, FLUSH=1 -> next cycle OUT_VALID=0, OUT_CTRL=CTRL_BUBBLE, OCCUPANCY=0, IN_READY=1; 0xC0 never appears.
- RESET and FLUSH together with accept in state ONE -> reset values; the following cycle the stage accepts a new 0x55 normally.
- SKID=0 build: OUT_READY=0 with head 0x77 -> IN_READY=0 in the same cycle. Raise OUT_READY with IN_VALID (0x88) -> 0x77 drained and 0x88 loaded at the same edge; OCCUPANCY never 2.
